// File: rtl/clause_dispatch_arbiter.sv
// Distributes up to NUM_IN clauses per cycle onto engines with free queue credit,
// using round-robin or fixed-priority scan order and registered per-engine push outputs.
module clause_dispatch_arbiter #(
  parameter  int NUM_ENGINE   = 4,
  parameter  int NUM_IN       = 4,
  parameter  int CLA_LENGTH   = 3,
  parameter  int LIT_W        = 5,
  parameter  int CREDIT_DEPTH = 4,
  localparam int CLA_W        = CLA_LENGTH * LIT_W,
  localparam int CNT_W        = $clog2(NUM_IN + 1),
  localparam int CRD_W        = $clog2(CREDIT_DEPTH + 1),
  localparam int IDX_W        = $clog2(NUM_ENGINE)
) (
  input  logic                                 clock,
  input  logic                                 reset,
  input  logic [NUM_IN-1:0][CLA_W-1:0]         clause_in,
  input  logic [CNT_W-1:0]                     clause_cnt_in,
  input  logic                                 mode_in,
  input  logic [NUM_ENGINE-1:0]                credit_return_in,
  output logic [CNT_W-1:0]                     clause_accept_out,
  output logic [NUM_ENGINE-1:0][CLA_W-1:0]     clause_out,
  output logic [NUM_ENGINE-1:0]                valid_out,
  output logic [NUM_ENGINE-1:0][CRD_W-1:0]     credit_out,
  output logic                                 credit_err_out
);

  logic [NUM_ENGINE-1:0][CRD_W-1:0] r_credit;
  logic [IDX_W-1:0]                 r_rr_ptr;
  logic [NUM_ENGINE-1:0]            r_valid;
  logic [NUM_ENGINE-1:0][CLA_W-1:0] r_clause;
  logic                             r_err;

  logic [CNT_W-1:0]                 w_cnt;
  logic [CNT_W-1:0]                 w_lane;
  logic [NUM_ENGINE-1:0]            w_grant;
  logic [NUM_ENGINE-1:0][CLA_W-1:0] w_lane_data;
  logic [IDX_W-1:0]                 w_last;
  logic [IDX_W-1:0]                 w_rr_nxt;
  logic [NUM_ENGINE-1:0][CRD_W-1:0] w_credit_nxt;
  logic                             w_err_set;

  // Walk the scan order; the k-th eligible engine takes lane k until the offered lanes run out.
  always_comb begin : p_arbitrate
    int idx;
    // NOTE: every variable gets a default before any conditional write so no latch is inferred.
    idx         = 0;
    w_grant     = '0;
    w_lane_data = '0;
    w_lane      = '0;
    w_last      = r_rr_ptr;
    w_cnt       = (clause_cnt_in > CNT_W'(NUM_IN)) ? CNT_W'(NUM_IN) : clause_cnt_in;
    if (!reset) begin
      for (int k = 0; k < NUM_ENGINE; k++) begin
        idx = mode_in ? k : (int'(r_rr_ptr) + k) % NUM_ENGINE;
        if ((r_credit[idx] != '0) && (w_lane < w_cnt)) begin
          w_grant[idx] = 1'b1;
          for (int l = 0; l < NUM_IN; l++) begin
            if (w_lane == CNT_W'(l)) w_lane_data[idx] = clause_in[l];
          end
          w_lane = w_lane + CNT_W'(1);
          w_last = IDX_W'(idx);
        end
      end
    end
  end

  always_comb begin : p_rr_next
    w_rr_nxt = (w_last == IDX_W'(NUM_ENGINE - 1)) ? '0 : w_last + IDX_W'(1);
  end

  // A return against a full queue is a protocol error: the credit saturates instead of wrapping.
  always_comb begin : p_credit_next
    w_credit_nxt = r_credit;
    w_err_set    = 1'b0;
    for (int i = 0; i < NUM_ENGINE; i++) begin
      case ({w_grant[i], credit_return_in[i]})
        2'b10:   w_credit_nxt[i] = r_credit[i] - CRD_W'(1);
        2'b01: begin
          if (r_credit[i] == CRD_W'(CREDIT_DEPTH)) w_err_set = 1'b1;
          else                                     w_credit_nxt[i] = r_credit[i] + CRD_W'(1);
        end
        2'b11: begin
          if (r_credit[i] == CRD_W'(CREDIT_DEPTH)) w_err_set = 1'b1;
        end
        default: w_credit_nxt[i] = r_credit[i];
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < NUM_ENGINE; i++) r_credit[i] <= CRD_W'(CREDIT_DEPTH);
      r_rr_ptr <= '0;
      r_valid  <= '0;
      r_clause <= '0;
      r_err    <= 1'b0;
    end else begin
      r_credit <= w_credit_nxt;
      r_valid  <= w_grant;
      r_clause <= w_lane_data;
      if (|w_grant) r_rr_ptr <= w_rr_nxt;
      if (w_err_set) r_err <= 1'b1;
    end
  end

  assign clause_accept_out = w_lane;
  assign clause_out        = r_clause;
  assign valid_out         = r_valid;
  assign credit_out        = r_credit;
  assign credit_err_out    = r_err;

endmodule

// File: tb/tb_clause_dispatch_arbiter.sv
// Directed bench for clause_dispatch_arbiter with default parameters
// (4 engines, 4 lanes, 15-bit clauses, credit depth 4).
module tb_clause_dispatch_arbiter;

  logic             clock;
  logic             reset;
  logic [3:0][14:0] cin;
  logic [2:0]       cnt;
  logic             mode;
  logic [3:0]       ret;
  logic [2:0]       accept;
  logic [3:0][14:0] cout;
  logic [3:0]       vout;
  logic [3:0][2:0]  crd;
  logic             err;

  int n_tests = 0;
  int n_fail  = 0;

  logic [3:0][14:0] exp_c;
  logic [3:0][2:0]  exp_cr;

  clause_dispatch_arbiter dut (
    .clock             (clock),
    .reset             (reset),
    .clause_in         (cin),
    .clause_cnt_in     (cnt),
    .mode_in           (mode),
    .credit_return_in  (ret),
    .clause_accept_out (accept),
    .clause_out        (cout),
    .valid_out         (vout),
    .credit_out        (crd),
    .credit_err_out    (err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [11:0] mk_cr(input int c0, input int c1, input int c2, input int c3);
    return {3'(c3), 3'(c2), 3'(c1), 3'(c0)};
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check_regs(input string tag, input logic [3:0] ev, input logic [59:0] ec,
                            input logic [11:0] ecr, input logic ee);
    chk({tag, ".valid"},  64'(vout), 64'(ev));
    chk({tag, ".clause"}, 64'(cout), 64'(ec));
    chk({tag, ".credit"}, 64'(crd),  64'(ecr));
    chk({tag, ".err"},    64'(err),  64'(ee));
  endtask

  initial begin
    reset = 1'b1; cnt = 3'd4; mode = 1'b0; ret = '0; cin = '0;
    tick(); tick();
    chk("reset.accept", 64'(accept), 64'd0);
    check_regs("reset", 4'b0000, '0, mk_cr(4, 4, 4, 4), 1'b0);

    // Idle after reset
    reset = 1'b0; cnt = 3'd0;
    for (int i = 0; i < 3; i++) begin
      #1 chk($sformatf("idle%0d.accept", i), 64'(accept), 64'd0);
      tick();
      check_regs($sformatf("idle%0d", i), 4'b0000, '0, mk_cr(4, 4, 4, 4), 1'b0);
    end

    // Round-robin fill: two lanes per cycle sweep the engines pairwise and wrap
    mode = 1'b0; cnt = 3'd2;
    exp_cr = mk_cr(4, 4, 4, 4);
    for (int c = 1; c <= 8; c++) begin
      int e0;
      e0 = (2 * (c - 1)) % 4;
      cin = '0;
      cin[0] = 15'(100 + c);
      cin[1] = 15'(200 + c);
      #1 chk($sformatf("rr%0d.accept", c), 64'(accept), 64'd2);
      tick();
      exp_c = '0;
      exp_c[e0]     = 15'(100 + c);
      exp_c[e0 + 1] = 15'(200 + c);
      exp_cr[e0]     = exp_cr[e0] - 3'd1;
      exp_cr[e0 + 1] = exp_cr[e0 + 1] - 3'd1;
      check_regs($sformatf("rr%0d", c), 4'(4'b0011 << e0), exp_c, exp_cr, 1'b0);
    end
    #1 chk("rr9.accept", 64'(accept), 64'd0);
    tick();
    check_regs("rr9", 4'b0000, '0, mk_cr(0, 0, 0, 0), 1'b0);

    // Returns are not usable in the cycle they arrive
    cnt = 3'd1; ret = 4'b1010;
    #1 chk("ret_same_cycle.accept", 64'(accept), 64'd0);
    tick();
    chk("ret1.credit", 64'(crd), 64'(mk_cr(0, 1, 0, 1)));
    cnt = 3'd0; ret = 4'b0010;
    tick(); tick();
    ret = 4'b0000;
    chk("ret3.credit", 64'(crd), 64'(mk_cr(0, 3, 0, 1)));

    // Single grant from rr_ptr=0 lands on engine 1 and moves rr_ptr to 2
    cnt = 3'd1; cin = '0; cin[0] = 15'h0AAA;
    #1 chk("pre.accept", 64'(accept), 64'd1);
    tick();
    exp_c = '0; exp_c[1] = 15'h0AAA;
    check_regs("pre", 4'b0010, exp_c, mk_cr(0, 2, 0, 1), 1'b0);

    // Partial eligibility: credits {0,2,0,1}, rr_ptr=2, four lanes offered
    cnt = 3'd4; cin[0] = 15'h0011; cin[1] = 15'h0022; cin[2] = 15'h0033; cin[3] = 15'h0044;
    #1 chk("partial.accept", 64'(accept), 64'd2);
    tick();
    exp_c = '0; exp_c[3] = 15'h0011; exp_c[1] = 15'h0022;
    check_regs("partial", 4'b1010, exp_c, mk_cr(0, 1, 0, 0), 1'b0);

    // rr_ptr is 2: with engines 0,1,2 eligible the scan must start at engine 2
    cnt = 3'd0; ret = 4'b0101;
    tick();
    ret = 4'b0000;
    chk("rrptr.prep.credit", 64'(crd), 64'(mk_cr(1, 1, 1, 0)));
    cnt = 3'd1; cin = '0; cin[0] = 15'h05A5;
    #1 chk("rrptr.accept", 64'(accept), 64'd1);
    tick();
    exp_c = '0; exp_c[2] = 15'h05A5;
    check_regs("rrptr", 4'b0100, exp_c, mk_cr(1, 1, 0, 0), 1'b0);

    // Fixed priority, engine 0 at credit 1 granted with a simultaneous return
    mode = 1'b1; cnt = 3'd1; ret = 4'b0001; cin[0] = 15'h0077;
    #1 chk("gr_ret.accept", 64'(accept), 64'd1);
    tick();
    exp_c = '0; exp_c[0] = 15'h0077;
    check_regs("gr_ret", 4'b0001, exp_c, mk_cr(1, 1, 0, 0), 1'b0);
    ret = 4'b0000; cin[0] = 15'h0066;
    #1 chk("gr_ret_next.accept", 64'(accept), 64'd1);
    tick();
    exp_c = '0; exp_c[0] = 15'h0066;
    check_regs("gr_ret_next", 4'b0001, exp_c, mk_cr(0, 1, 0, 0), 1'b0);

    // Round-robin from rr_ptr=1 grants engine 1, then reset drops everything
    mode = 1'b0; cin[0] = 15'h0055;
    #1 chk("pre_rst.accept", 64'(accept), 64'd1);
    tick();
    exp_c = '0; exp_c[1] = 15'h0055;
    check_regs("pre_rst", 4'b0010, exp_c, mk_cr(0, 0, 0, 0), 1'b0);
    reset = 1'b1;
    tick();
    check_regs("mid_rst", 4'b0000, '0, mk_cr(4, 4, 4, 4), 1'b0);
    reset = 1'b0;

    // Fixed priority with count clamped from 7 to 4
    mode = 1'b1; cnt = 3'd7;
    cin[0] = 15'h0101; cin[1] = 15'h0202; cin[2] = 15'h0303; cin[3] = 15'h0404;
    #1 chk("clamp.accept", 64'(accept), 64'd4);
    tick();
    check_regs("clamp", 4'b1111, {15'h0404, 15'h0303, 15'h0202, 15'h0101}, mk_cr(3, 3, 3, 3), 1'b0);

    // Credit overflow on engine 2
    mode = 1'b0; cnt = 3'd0; ret = 4'b0100;
    tick();
    check_regs("ovf_fill", 4'b0000, '0, mk_cr(3, 3, 4, 3), 1'b0);
    tick();
    check_regs("ovf", 4'b0000, '0, mk_cr(3, 3, 4, 3), 1'b1);
    ret = 4'b0000;
    tick(); tick();
    check_regs("ovf_sticky", 4'b0000, '0, mk_cr(3, 3, 4, 3), 1'b1);
    reset = 1'b1;
    tick();
    check_regs("ovf_clear", 4'b0000, '0, mk_cr(4, 4, 4, 4), 1'b0);
    reset = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/clause_dispatch_arbiter.md
Name: clause_dispatch_arbiter

Overview:
Parametrised clause distributor between the clause source and the BCP engine array. It accepts up to NUM_IN clauses per cycle and assigns each accepted clause to a distinct engine that has free queue space. Engine space is tracked by per-engine credit counters, not combinational full flags. Supports round-robin or fixed-priority selection, with registered outputs to the engines.

Parameters:
NUM_ENGINE, 4, number of downstream engines (>=2)
NUM_IN, 4, number of input clause lanes offered per cycle (1..NUM_ENGINE)
CLA_LENGTH, 3, literals per clause
LIT_W, 5, bits per literal
CREDIT_DEPTH, 4, entries in each engine's input queue; initial credit value
(derived) CLA_W = CLA_LENGTH*LIT_W; CNT_W = $clog2(NUM_IN+1); CRD_W = $clog2(CREDIT_DEPTH+1); IDX_W = $clog2(NUM_ENGINE)

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high reset
clause_in  in  NUM_IN x CLA_W  offered clauses; lane 0 is oldest
clause_cnt_in  in  CNT_W  number of valid lanes (lanes 0..cnt-1); values >NUM_IN are clamped to NUM_IN
mode_in  in  1  0 = round-robin, 1 = fixed priority (engine 0 highest)
credit_return_in  in  NUM_ENGINE  pulse: engine i popped one queue entry
clause_accept_out  out  CNT_W  combinational; lanes 0..accept-1 consumed this cycle
clause_out  out  NUM_ENGINE x CLA_W  registered clause per engine; zero when not valid
valid_out  out  NUM_ENGINE  registered; 1-cycle push strobe per engine
credit_out  out  NUM_ENGINE x CRD_W  current credit per engine (debug)
credit_err_out  out  1  sticky; set on credit_return_in while credit == CREDIT_DEPTH

Behaviour:
- Reset (synchronous, active-high): credit[i] = CREDIT_DEPTH, rr_ptr = 0, valid_out = 0, clause_out = 0, credit_err_out = 0. clause_accept_out = 0 while reset is high.
- Eligibility: engine i is eligible iff the registered credit[i] > 0. A credit returned in cycle t is not usable before cycle t+1.
- Scan order:
  - mode 0: engines rr_ptr, rr_ptr+1, ... mod NUM_ENGINE.
  - mode 1: engines 0..NUM_ENGINE-1.
- Assignment: walk the scan order. The k-th eligible engine encountered receives lane k, while k < min(clause_cnt_in clamped, NUM_IN). Each engine gets at most one clause per cycle.
- accept = number of lanes assigned = min(cnt, eligible count). Lanes are always consumed in order, with no gaps.
- Latency: assignment is decided combinationally in cycle t. clause_out[i] and valid_out[i] are registered and appear in cycle t+1 for exactly one cycle. Non-granted engines show valid_out = 0 and clause_out = 0.
- Credit update per engine: credit_next = credit - grant + return.
  - grant and return in the same cycle: credit unchanged.
  - grant only when credit == 1: credit becomes 0 and the engine is ineligible next cycle.
  - return while credit == CREDIT_DEPTH: credit held (saturates) and credit_err_out set. credit_err_out clears only on reset.
- rr_ptr update (all modes): if any grant, rr_ptr <= (index of last engine granted in scan order + 1) mod NUM_ENGINE. If no grant, rr_ptr is held. mode_in may change on any cycle and takes effect in the same cycle.
- Boundaries:
  - clause_cnt_in = 0: no grants, accept = 0, credits change only by returns.
  - All engines at credit 0: accept = 0 regardless of cnt.
  - rr_ptr wraps from NUM_ENGINE-1 to 0.
  - Reset asserted mid-stream: valid_out is 0 in the following cycle, and in-flight registered outputs are dropped.

Test Plan:
- Reset then idle: NUM_ENGINE=4, CREDIT_DEPTH=4, cnt=0 for 3 cycles -> valid_out=0000, credit_out all 4, accept=0, credit_err_out=0.
- Round-robin fill: mode 0, cnt=2 every cycle, no returns -> cycle1 lanes to engines 0,1; cycle2 to 2,3; cycle3 to 0,1; ... After 8 cycles all credits are 0; on cycle 9 accept=0 and valid_out=0000 in cycle 10.
- Partial eligibility: credits {0,2,0,1}, rr_ptr=2, mode 0, cnt=4 -> accept=2; lane0->engine 3, lane1->engine 1; next rr_ptr=2; next-cycle valid_out=1010 with matching clause data.
- Simultaneous grant and return: engine 0 at credit 1 is granted while credit_return_in[0]=1 -> credit stays 1; engine 0 remains eligible next cycle.
- Fixed priority plus clamp: mode 1, all credits 4, cnt=7 (clamped to 4) with NUM_IN=4 -> accept=4; lanes 0..3 go to engines 0..3 in order.
- Credit overflow: credit_return_in[2]=1 while credit[2]=4 -> credit[2] stays 4, credit_err_out=1 and stays 1 until reset.
